// File: rtl/tt_um_eskimohunter_spi_regs.sv
// SPI mode-0 slave in front of 8x8 registers (reg 7 counts completed frames), inputs synchronised to clk.
// Latency: write lands 1 clk after the 16th sclk rise is seen, uo_out 1 clk later; backpressure: none, paced by the SPI master.
module tt_um_eskimohunter_spi_regs #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic [SYNC_STAGES-1:0] flush_q;
    logic                   sclk_prev_q;
    logic                   csn_prev_q;

    logic                   csn_in;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   csn_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   csn_fall;

    state_t                 state_q;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             cmd_q;
    logic [7:0]             dat_q;
    logic [7:0]             miso_sr_q;
    logic                   miso_q;
    logic                   wr_pend_q;
    logic                   armed_q;
    logic [7:0]             uo_q;
    logic [7:0]             regs_q [8];

    logic [7:0]             cmd_nxt;
    logic [7:0]             dat_nxt;
    logic                   unused_ok;

    // A disabled design looks exactly like a deselected one.
    assign csn_in = ui_in[2] | ~ena;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csn_sync_q  <= '1;
            flush_q     <= '0;
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ui_in[0]};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], ui_in[1]};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn_in};
            flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            csn_prev_q  <= csn_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign csn_fall  = ~csn_s & csn_prev_q;

    assign cmd_nxt = {cmd_q[6:0], mosi_s};
    assign dat_nxt = {dat_q[6:0], mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            cmd_q     <= 8'h00;
            dat_q     <= 8'h00;
            miso_sr_q <= 8'h00;
            miso_q    <= 1'b0;
            wr_pend_q <= 1'b0;
            armed_q   <= 1'b0;
            uo_q      <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            // Only a cs_n fall seen after a genuine high sample starts a frame,
            // so a frame interrupted by reset is never picked up half-way.
            armed_q   <= armed_q | (flush_q[SYNC_STAGES-1] & csn_s);
            uo_q      <= regs_q[0];
            wr_pend_q <= 1'b0;
            if (wr_pend_q) begin
                regs_q[cmd_q[2:0]] <= dat_q;
            end

            if (csn_s) begin
                state_q   <= IDLE;
                bit_cnt_q <= 3'd0;
                miso_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (csn_fall && armed_q) begin
                            state_q   <= CMD;
                            bit_cnt_q <= 3'd0;
                            miso_q    <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            cmd_q     <= cmd_nxt;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= DATA;
                                if (!cmd_nxt[7]) begin
                                    miso_sr_q <= regs_q[cmd_nxt[2:0]];
                                    miso_q    <= regs_q[cmd_nxt[2:0]][7];
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_rise) begin
                            dat_q     <= dat_nxt;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q    <= DONE;
                                miso_q     <= 1'b0;
                                regs_q[7]  <= regs_q[7] + 8'd1;
                                wr_pend_q  <= cmd_q[7] && (cmd_q[2:0] != 3'd7);
                            end
                        end else if (sclk_fall && !cmd_q[7] && bit_cnt_q != 3'd0) begin
                            // The fall trailing the last command rise must not
                            // shift, or bit 7 never reaches the master.
                            miso_sr_q <= {miso_sr_q[6:0], 1'b0};
                            miso_q    <= miso_sr_q[6];
                        end
                    end
                    DONE: begin
                        bit_cnt_q <= 3'd0;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign uo_out    = uo_q;
    assign uio_out   = {7'b0, miso_q & ~csn_s};
    assign uio_oe    = 8'h01;
    assign unused_ok = &{1'b0, uio_in, ui_in[7:3], cmd_q[6:3]};

endmodule

// File: tb/tb_tt_um_eskimohunter_spi_regs.sv
// Bench for the SPI register block: fixed vectors, random frames against a register-file model, corner sequences.
module tb_tt_um_eskimohunter_spi_regs;

    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       csn = 1'b1;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] ui_in;
    logic       miso;

    int total = 0;
    int bad = 0;

    logic [7:0] m_regs [8];

    assign ui_in = {5'b0, csn, mosi, sclk};
    assign miso  = uio_out[0];

    always #5 clk = ~clk;

    tt_um_eskimohunter_spi_regs #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (8'h00),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] dat;
        int         nrise;
        logic [7:0] exp_rx;
        logic [7:0] exp_uo;
    } vec_t;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    // Register-file view of a frame: a read returns the value at command time;
    // only a frame with at least 16 rises commits and bumps the count.
    function automatic logic [7:0] model_frame(input logic [7:0] cmd, input logic [7:0] dat, input int nrise);
        logic [7:0] rd;
        logic [2:0] a;
        a  = cmd[2:0];
        rd = cmd[7] ? 8'h00 : m_regs[a];
        if (nrise >= 16) begin
            if (cmd[7] && a != 3'd7) m_regs[a] = dat;
            m_regs[7] = m_regs[7] + 8'd1;
        end
        return rd;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        csn = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        ena = 1'b1;
        repeat (5) @(negedge clk);
        check8("rst_uo_during", uo_out, 8'h00);
        check8("rst_uio_out_during", uio_out, 8'h00);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        model_reset();
    endtask

    task automatic xfer(input logic [7:0] cmd, input logic [7:0] dat, input int nrise, input int rst_at,
                        input bit ena_abort, input bit glitch, output logic [7:0] rx);
        logic [15:0] word;
        word = {cmd, dat};
        rx = 8'h00;
        @(negedge clk);
        csn = 1'b0;
        if (glitch) begin
            sclk = 1'b1;
            mosi = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        if (glitch) begin
            sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        for (int i = 0; i < nrise; i++) begin
            mosi = (i < 16) ? word[15-i] : 1'b0;
            if (i == rst_at) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
            repeat (HALF) @(negedge clk);
            if (i >= 8 && i < 16) rx = {rx[6:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        if (ena_abort) begin
            ena = 1'b0;
            repeat (8) @(negedge clk);
        end
        csn = 1'b1;
        ena = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic run_checked(input string name, input logic [7:0] cmd, input logic [7:0] dat, input int nrise);
        logic [7:0] rx;
        logic [7:0] exp;
        xfer(cmd, dat, nrise, -1, 1'b0, 1'b0, rx);
        exp = model_frame(cmd, dat, nrise);
        if (nrise >= 16) check8({name, "_rx"}, rx, exp);
        check8({name, "_uo"}, uo_out, m_regs[0]);
        check8({name, "_idle_uio"}, uio_out, 8'h00);
    endtask

    initial begin
        vec_t       vecs [12];
        logic [7:0] rx;
        int         nr;
        int         r;

        vecs[0]  = '{8'h80, 8'hA5, 16, 8'h00, 8'hA5};
        vecs[1]  = '{8'h00, 8'h00, 16, 8'hA5, 8'hA5};
        vecs[2]  = '{8'h07, 8'h00, 16, 8'h02, 8'hA5};
        vecs[3]  = '{8'h83, 8'h5A, 12, 8'h00, 8'hA5};
        vecs[4]  = '{8'h03, 8'h00, 16, 8'h00, 8'hA5};
        vecs[5]  = '{8'h07, 8'h00, 16, 8'h04, 8'hA5};
        vecs[6]  = '{8'h87, 8'hFF, 16, 8'h00, 8'hA5};
        vecs[7]  = '{8'h07, 8'h00, 16, 8'h06, 8'hA5};
        vecs[8]  = '{8'h8B, 8'h3C, 16, 8'h00, 8'hA5};
        vecs[9]  = '{8'h7B, 8'h00, 16, 8'h3C, 8'hA5};
        vecs[10] = '{8'h80, 8'h00, 20, 8'h00, 8'h00};
        vecs[11] = '{8'h07, 8'h00, 16, 8'h0A, 8'h00};

        // Reset values and the first read of the counter.
        do_reset();
        check8("rst_uo", uo_out, 8'h00);
        check8("rst_uio_oe", uio_oe, 8'h01);
        check8("rst_miso", uio_out, 8'h00);
        xfer(8'h07, 8'h00, 16, -1, 1'b0, 1'b0, rx);
        check8("rst_read_cnt", rx, 8'h00);
        void'(model_frame(8'h07, 8'h00, 16));

        // Fixed vectors from a fresh reset.
        do_reset();
        for (int v = 0; v < 12; v++) begin
            xfer(vecs[v].cmd, vecs[v].dat, vecs[v].nrise, -1, 1'b0, 1'b0, rx);
            void'(model_frame(vecs[v].cmd, vecs[v].dat, vecs[v].nrise));
            check8($sformatf("vec%0d_rx", v), rx, vecs[v].exp_rx);
            check8($sformatf("vec%0d_uo", v), uo_out, vecs[v].exp_uo);
        end

        // Random frames, including partial and over-long ones.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2) nr = $urandom_range(1, 15);
            else if (r < 4) nr = $urandom_range(17, 20);
            else nr = 16;
            run_checked($sformatf("rnd%0d", k), 8'($urandom), 8'($urandom), nr);
        end
        run_checked("rnd_cnt", 8'h07, 8'h00, 16);

        // cs_n fall coinciding with an sclk rise: that rise must not shift.
        xfer(8'h81, 8'h5A, 16, -1, 1'b0, 1'b1, rx);
        void'(model_frame(8'h81, 8'h5A, 16));
        run_checked("glitch_reg1", 8'h01, 8'h00, 16);

        // ena dropped mid-frame aborts like a cs_n rise.
        xfer(8'h82, 8'h77, 12, -1, 1'b1, 1'b0, rx);
        void'(model_frame(8'h82, 8'h77, 12));
        run_checked("ena_abort_reg2", 8'h02, 8'h00, 16);
        run_checked("ena_abort_cnt", 8'h07, 8'h00, 16);

        // Reset pulsed during DATA of a write, master keeps clocking.
        xfer(8'h80, 8'h3C, 16, 10, 1'b0, 1'b0, rx);
        model_reset();
        check8("midrst_uo", uo_out, 8'h00);
        check8("midrst_miso", uio_out, 8'h00);
        xfer(8'h80, 8'h11, 16, -1, 1'b0, 1'b0, rx);
        void'(model_frame(8'h80, 8'h11, 16));
        check8("midrst_next_uo", uo_out, 8'h11);
        run_checked("midrst_cnt", 8'h07, 8'h00, 16);

        // 256 complete frames wrap the counter back to zero.
        do_reset();
        for (int k = 0; k < 256; k++) begin
            xfer(8'h81, 8'(k), 16, -1, 1'b0, 1'b0, rx);
            void'(model_frame(8'h81, 8'(k), 16));
        end
        xfer(8'h07, 8'h00, 16, -1, 1'b0, 1'b0, rx);
        void'(model_frame(8'h07, 8'h00, 16));
        check8("wrap_cnt", rx, 8'h00);
        run_checked("wrap_reg1", 8'h01, 8'h00, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_um_eskimohunter_spi_regs.md
TT_UM_ESKIMOHUNTER_SPI_REGS -- requirements
Module: tt_um_eskimohunter_spi_regs

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchroniser flops on each SPI input (legal values 2..3).
REQ-002 clk  input  1  system clock; all state is in this single clock domain.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ena  input  1  design-select; while low, the SPI inputs are treated as cs_n=1.
REQ-005 ui_in  input  8  [0]=sclk, [1]=mosi, [2]=cs_n; [7:3] unused.
REQ-006 uo_out  output  8  continuous copy of register 0.
REQ-007 uio_in  input  8  unused.
REQ-008 uio_out  output  8  [0]=miso; [7:1] constant 0.
REQ-009 uio_oe  output  8  constant 8'h01.

Function
REQ-010 The block SHALL pass sclk, mosi and cs_n through SYNC_STAGES flops, then detect sclk rise/fall as a change between the last two synchronised samples.
REQ-011 Supported SPI mode: mode 0 (CPOL=0, CPHA=0), MSB first, with sclk period >= 8 clk periods and cs_n setup/hold >= 4 clk periods.
REQ-012 Register file: 8 x 8-bit registers. Registers 0..6 are read/write. Register 7 is a read-only transaction counter.
REQ-013 Frame format: command byte, then data byte. Command bit7=1 means write, 0 means read; bits[2:0]=addr; bits[6:3] are ignored.
REQ-014 FSM states and transitions:
- IDLE -> CMD on a synchronised cs_n fall.
- CMD -> DATA after the 8th sclk rise.
- DATA -> DONE after the 8th sclk rise.
- DONE -> IDLE on a cs_n rise.
REQ-015 A synchronised cs_n rise in any state SHALL force IDLE and clear the bit counter. A partial frame SHALL cause no register write and no counter increment.
REQ-016 CMD: on each sclk rise, mosi SHALL be shifted into the command shift register; a 3-bit counter SHALL count 0..7.
REQ-017 On the 8th CMD rise of a read, the MISO shift register SHALL load reg[addr] in the same cycle, and miso SHALL present bit7 immediately.
REQ-018 DATA, read: miso SHALL shift to the next bit on each sclk fall. After bit0, miso SHALL hold 0.
REQ-019 DATA, write: on each sclk rise, mosi SHALL shift into the data register. On the 8th rise, reg[addr] SHALL update in the following clk cycle; writes to addr 7 are ignored.
REQ-020 The counter (reg 7) SHALL increment by 1 modulo 256 (wraps 255 -> 0) on every completed 16-bit frame, read or write, when DATA -> DONE.
REQ-021 In DONE, further sclk edges SHALL be ignored, with no wrap into a new frame.
REQ-022 miso SHALL be 0 whenever the state is IDLE or CMD, or the synchronised cs_n is 1.
REQ-023 If a cs_n fall and an sclk edge appear in the same synchronised cycle, the cs_n fall takes priority and that sclk edge is ignored.
REQ-024 If ena goes low mid-frame, the block SHALL abort exactly as for a cs_n rise (REQ-015).
REQ-025 Read data SHALL be a snapshot taken at load time (REQ-017). A simultaneous write to the same register SHALL NOT alter the bits in flight.
REQ-026 uo_out SHALL reflect a reg 0 write one clk after the register update.

Reset
REQ-027 On rst_n=0, the following SHALL clear asynchronously and independent of clk: all registers including the counter, all shift registers and bit counters, and the synchronisers. Synchronisers clear to sclk=0, mosi=0, cs_n=1.
REQ-028 During and after reset: FSM=IDLE, uo_out=8'h00, uio_out=8'h00, uio_oe=8'h01.
REQ-029 rst_n asserted mid-frame SHALL discard the frame. After rst_n is released, the first frame recognised SHALL be one that starts with a fresh cs_n fall.

Verification
REQ-030 Reset: rst_n=0 for 5 clk, then release -> uo_out=8'h00, uio_oe=8'h01, miso=0; a read of addr 7 returns 8'h00.
REQ-031 Write then read: frame {8'h80, 8'hA5} -> uo_out=8'hA5. Frame {8'h00, 8'h00} -> miso returns 8'hA5, and reg 7 reads 8'h02 afterwards.
REQ-032 Abort: write addr 3 with cs_n raised after 12 sclk rises -> reg3 unchanged (8'h00) and counter unchanged.
REQ-033 Read-only: frame {8'h87, 8'hFF} -> counter increments by 1 and is not set to 8'hFF. A subsequent read of addr 7 returns the previous count + 1.
REQ-034 Counter wrap: 256 complete frames -> reg 7 reads 8'h00 on the next read. Extra sclk edges after 16 within one frame -> no second increment.
REQ-035 Async reset mid-frame: pulse rst_n low during DATA of a write of 8'h3C to addr 0 -> uo_out=8'h00. The next full frame, write 8'h11 to addr 0, then works: uo_out=8'h11.
